// File: rtl/trap_pkg.sv
// Shared types and constants for the moving-trap sprite: state encoding,
// behaviour modes, screen bounds and signed coordinate helpers.
package trap_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_DONE   = 2'd2,
    ST_WAIT   = 2'd3
  } trap_state_t;

  localparam int MODE_ONESHOT = 0;
  localparam int MODE_RESPAWN = 1;

  localparam int SCREEN_W = 800;
  localparam int SCREEN_H = 600;

  localparam int POS_W = 12;
  // One guard bit so pos+size and pos±window never wrap.
  localparam int EXT_W = POS_W + 1;

  function automatic logic signed [EXT_W-1:0] sext(input logic signed [POS_W-1:0] v);
    return {v[POS_W-1], v};
  endfunction

  function automatic logic signed [EXT_W-1:0] pix2s(input logic [9:0] v);
    return {3'b000, v};
  endfunction

endpackage

// File: rtl/trap_sprite_if.sv
// Bundle between the game logic / pixel mux and one trap sprite instance.
interface trap_sprite_if #(
  parameter int ADDR_W = 11
);
  // No backpressure anywhere: restart/update_tick/toggle_tick are one-cycle
  // strobes, and rom_rgb must carry the word for rom_addr one cycle later.
  logic              restart;
  logic              update_tick;
  logic              toggle_tick;
  logic [9:0]        col;
  logic [9:0]        row;
  logic [9:0]        kid_x;
  logic [9:0]        kid_y;
  logic [ADDR_W-1:0] rom_addr;
  logic [11:0]       rom_rgb;
  logic              is_obj;
  logic [11:0]       obj_rgb;
  logic              hit;
  logic [1:0]        state_o;

  modport master (
    output restart, update_tick, toggle_tick, col, row, kid_x, kid_y, rom_rgb,
    input  rom_addr, is_obj, obj_rgb, hit, state_o
  );

  modport slave (
    input  restart, update_tick, toggle_tick, col, row, kid_x, kid_y, rom_rgb,
    output rom_addr, is_obj, obj_rgb, hit, state_o
  );
endinterface

// File: rtl/trap_motion.sv
// Trap motion state machine: waits for the kid to enter the trigger window,
// then moves with accelerating, saturated velocity until it leaves the screen.
module trap_motion
  import trap_pkg::*;
#(
  parameter int INIT_X      = 100,
  parameter int INIT_Y      = 200,
  parameter int OBJ_W       = 22,
  parameter int OBJ_H       = 24,
  parameter int AXIS        = 0,
  parameter int INIT_VEL    = 1,
  parameter int ACCEL       = 0,
  parameter int MAX_VEL     = 8,
  parameter int TRIG_AXIS   = 0,
  parameter int TRIG_W      = 22,
  parameter int MODE        = 0,
  parameter int RESPAWN_DLY = 60
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    i_restart,
  input  logic                    i_update_tick,
  input  logic [9:0]              i_kid_x,
  input  logic [9:0]              i_kid_y,
  output logic signed [POS_W-1:0] o_pos_x,
  output logic signed [POS_W-1:0] o_pos_y,
  output trap_state_t             o_state
);

  localparam int CNT_W = 16;

  localparam logic signed [POS_W-1:0] L_INIT_X   = POS_W'(INIT_X);
  localparam logic signed [POS_W-1:0] L_INIT_Y   = POS_W'(INIT_Y);
  localparam logic signed [POS_W-1:0] L_INIT_VEL = POS_W'(INIT_VEL);
  localparam logic signed [POS_W-1:0] L_VMAX     = POS_W'(MAX_VEL);
  localparam logic signed [POS_W-1:0] L_VMIN     = POS_W'(-MAX_VEL);
  localparam logic signed [EXT_W-1:0] L_VMAX_E   = EXT_W'(MAX_VEL);
  localparam logic signed [EXT_W-1:0] L_VMIN_E   = EXT_W'(-MAX_VEL);
  localparam logic signed [EXT_W-1:0] L_ACCEL    = EXT_W'(ACCEL);
  localparam logic signed [EXT_W-1:0] L_TRIG_W   = EXT_W'(TRIG_W);
  localparam logic signed [EXT_W-1:0] L_SIZE     = EXT_W'((AXIS == 1) ? OBJ_W : OBJ_H);
  localparam logic signed [EXT_W-1:0] L_LIMIT    = EXT_W'((AXIS == 1) ? SCREEN_W : SCREEN_H);
  localparam logic signed [EXT_W-1:0] L_ZERO     = '0;
  localparam logic [CNT_W-1:0]        L_DLY      = CNT_W'(RESPAWN_DLY);

  trap_state_t             r_state;
  logic signed [POS_W-1:0] r_pos_x;
  logic signed [POS_W-1:0] r_pos_y;
  logic signed [POS_W-1:0] r_vel;
  logic [CNT_W-1:0]        r_cnt;

  logic signed [POS_W-1:0] w_pos_axis;
  logic signed [POS_W-1:0] w_pos_next;
  logic signed [POS_W-1:0] w_vel_next;
  logic signed [EXT_W-1:0] w_next_ext;
  logic signed [EXT_W-1:0] w_vel_sum;
  logic signed [EXT_W-1:0] w_trig_t;
  logic signed [EXT_W-1:0] w_trig_pos;
  logic                    w_off;
  logic                    w_trig;

  always_comb begin
    w_pos_axis = (AXIS == 1) ? r_pos_x : r_pos_y;
    w_pos_next = w_pos_axis + r_vel;
    w_next_ext = sext(w_pos_next);
    w_off      = ((w_next_ext + L_SIZE) <= L_ZERO) || (w_next_ext >= L_LIMIT);

    w_vel_sum = sext(r_vel) + L_ACCEL;
    if (w_vel_sum > L_VMAX_E)      w_vel_next = L_VMAX;
    else if (w_vel_sum < L_VMIN_E) w_vel_next = L_VMIN;
    else                           w_vel_next = w_vel_sum[POS_W-1:0];

    w_trig_t   = (TRIG_AXIS == 1) ? pix2s(i_kid_y) : pix2s(i_kid_x);
    w_trig_pos = sext((TRIG_AXIS == 1) ? r_pos_y : r_pos_x);
    w_trig     = (w_trig_t >= (w_trig_pos - L_TRIG_W)) && (w_trig_t < (w_trig_pos + L_TRIG_W));
  end

  // restart outranks a coincident update_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_pos_x <= L_INIT_X;
      r_pos_y <= L_INIT_Y;
      r_vel   <= '0;
      r_cnt   <= '0;
    end else if (i_restart) begin
      r_state <= ST_IDLE;
      r_pos_x <= L_INIT_X;
      r_pos_y <= L_INIT_Y;
      r_vel   <= '0;
      r_cnt   <= '0;
    end else if (i_update_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (w_trig) begin
            r_state <= ST_MOVING;
            r_vel   <= L_INIT_VEL;
          end
        end
        ST_MOVING: begin
          if (AXIS == 1) r_pos_x <= w_pos_next;
          else           r_pos_y <= w_pos_next;
          r_vel <= w_vel_next;
          if (w_off) begin
            if (MODE == MODE_RESPAWN) begin
              r_state <= ST_WAIT;
              r_cnt   <= L_DLY;
            end else begin
              r_state <= ST_DONE;
            end
          end
        end
        ST_WAIT: begin
          // The tick that takes the count to zero is the respawn tick.
          if (r_cnt <= CNT_W'(1)) begin
            r_state <= ST_IDLE;
            r_pos_x <= L_INIT_X;
            r_pos_y <= L_INIT_Y;
            r_vel   <= '0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign o_pos_x = r_pos_x;
  assign o_pos_y = r_pos_y;
  assign o_state = r_state;

endmodule

// File: rtl/trap_sprite.sv
// Moving-trap sprite top: motion core plus pixel path (ROM addressing,
// colour-key transparency), animation frame counter and kid hit detection.
module trap_sprite
  import trap_pkg::*;
#(
  parameter int          INIT_X      = 100,
  parameter int          INIT_Y      = 200,
  parameter int          OBJ_W       = 22,
  parameter int          OBJ_H       = 24,
  parameter int          AXIS        = 0,
  parameter int          INIT_VEL    = 1,
  parameter int          ACCEL       = 0,
  parameter int          MAX_VEL     = 8,
  parameter int          TRIG_AXIS   = 0,
  parameter int          TRIG_W      = 22,
  parameter int          MODE        = 0,
  parameter int          RESPAWN_DLY = 60,
  parameter int          FRAMES      = 2,
  parameter int          KID_W       = 11,
  parameter int          KID_H       = 21,
  parameter logic [11:0] COLOR_KEY   = 12'h000,
  parameter int          ADDR_W      = 11
) (
  input logic          clk,
  input logic          rst_n,
  trap_sprite_if.slave bus
);

  localparam int FR_W = (FRAMES > 1) ? $clog2(FRAMES) : 1;
  localparam logic [FR_W-1:0]         L_FR_LAST = FR_W'(FRAMES - 1);
  localparam logic signed [EXT_W-1:0] L_OBJ_W   = EXT_W'(OBJ_W);
  localparam logic signed [EXT_W-1:0] L_OBJ_H   = EXT_W'(OBJ_H);
  localparam logic signed [EXT_W-1:0] L_KID_W   = EXT_W'(KID_W);
  localparam logic signed [EXT_W-1:0] L_KID_H   = EXT_W'(KID_H);
  localparam logic signed [EXT_W-1:0] L_ZERO    = '0;

  logic signed [POS_W-1:0] w_pos_x;
  logic signed [POS_W-1:0] w_pos_y;
  trap_state_t             w_state;

  trap_motion #(
    .INIT_X(INIT_X), .INIT_Y(INIT_Y), .OBJ_W(OBJ_W), .OBJ_H(OBJ_H),
    .AXIS(AXIS), .INIT_VEL(INIT_VEL), .ACCEL(ACCEL), .MAX_VEL(MAX_VEL),
    .TRIG_AXIS(TRIG_AXIS), .TRIG_W(TRIG_W), .MODE(MODE), .RESPAWN_DLY(RESPAWN_DLY)
  ) u_motion (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_restart    (bus.restart),
    .i_update_tick(bus.update_tick),
    .i_kid_x      (bus.kid_x),
    .i_kid_y      (bus.kid_y),
    .o_pos_x      (w_pos_x),
    .o_pos_y      (w_pos_y),
    .o_state      (w_state)
  );

  logic [FR_W-1:0] r_frame;
  logic            r_in_box_d;
  logic            r_hit;

  logic                    w_visible;
  logic signed [EXT_W-1:0] w_px, w_py, w_kx, w_ky, w_dx, w_dy;
  logic                    w_in_box;
  logic                    w_overlap;
  logic [ADDR_W-1:0]       w_addr;
  logic                    w_is_obj;

  always_comb begin
    w_visible = (w_state == ST_IDLE) || (w_state == ST_MOVING);
    w_px      = sext(w_pos_x);
    w_py      = sext(w_pos_y);
    w_kx      = pix2s(bus.kid_x);
    w_ky      = pix2s(bus.kid_y);
    w_dx      = pix2s(bus.col) - w_px;
    w_dy      = pix2s(bus.row) - w_py;
    w_in_box  = (w_dx >= L_ZERO) && (w_dx < L_OBJ_W) && (w_dy >= L_ZERO) && (w_dy < L_OBJ_H);
    // Only meaningful inside the box, so the truncating casts are safe there.
    w_addr    = ADDR_W'(r_frame) * ADDR_W'(OBJ_W * OBJ_H)
              + ADDR_W'(w_dy) * ADDR_W'(OBJ_W) + ADDR_W'(w_dx);
    w_overlap = (w_kx < (w_px + L_OBJ_W)) && (w_px < (w_kx + L_KID_W)) &&
                (w_ky < (w_py + L_OBJ_H)) && (w_py < (w_ky + L_KID_H));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame <= '0;
    end else if (bus.restart) begin
      r_frame <= '0;
    end else if (bus.toggle_tick) begin
      r_frame <= (r_frame == L_FR_LAST) ? '0 : r_frame + FR_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_box_d <= 1'b0;
      r_hit      <= 1'b0;
    end else begin
      r_in_box_d <= w_in_box && w_visible;
      r_hit      <= w_overlap && w_visible;
    end
  end

  assign w_is_obj     = r_in_box_d && (bus.rom_rgb != COLOR_KEY);
  assign bus.rom_addr = w_in_box ? w_addr : '0;
  assign bus.is_obj   = w_is_obj;
  assign bus.obj_rgb  = w_is_obj ? bus.rom_rgb : 12'h000;
  assign bus.hit      = r_hit;
  assign bus.state_o  = w_state;

endmodule

// File: tb/tb_trap_sprite.sv
// Bench for trap_sprite: three instances (defaults, accelerating, respawning)
// driven in parallel and checked against an integer behavioural model.
module tb_trap_sprite;

  localparam int S_IDLE = 0, S_MOVING = 1, S_DONE = 2, S_WAIT = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        restart = 1'b0, update_tick = 1'b0, toggle_tick = 1'b0;
  logic [9:0]  col = '0, row = '0, kid_x = 10'd300, kid_y = '0;
  logic [11:0] rom_rgb = '0;

  trap_sprite_if #(.ADDR_W(11)) if_a ();
  trap_sprite_if #(.ADDR_W(11)) if_b ();
  trap_sprite_if #(.ADDR_W(11)) if_c ();

  assign {if_a.restart, if_a.update_tick, if_a.toggle_tick, if_a.col, if_a.row, if_a.kid_x, if_a.kid_y, if_a.rom_rgb} =
         {restart, update_tick, toggle_tick, col, row, kid_x, kid_y, rom_rgb};
  assign {if_b.restart, if_b.update_tick, if_b.toggle_tick, if_b.col, if_b.row, if_b.kid_x, if_b.kid_y, if_b.rom_rgb} =
         {restart, update_tick, toggle_tick, col, row, kid_x, kid_y, rom_rgb};
  assign {if_c.restart, if_c.update_tick, if_c.toggle_tick, if_c.col, if_c.row, if_c.kid_x, if_c.kid_y, if_c.rom_rgb} =
         {restart, update_tick, toggle_tick, col, row, kid_x, kid_y, rom_rgb};

  trap_sprite dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));
  trap_sprite #(.ACCEL(1), .MAX_VEL(3)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));
  trap_sprite #(.MODE(1), .RESPAWN_DLY(3)) dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c.slave));

  logic [1:0]  st[3];
  logic [10:0] ra[3];
  logic        iso[3];
  logic [11:0] rgb[3];
  logic        ht[3];
  assign st[0] = if_a.state_o;  assign st[1] = if_b.state_o;  assign st[2] = if_c.state_o;
  assign ra[0] = if_a.rom_addr; assign ra[1] = if_b.rom_addr; assign ra[2] = if_c.rom_addr;
  assign iso[0] = if_a.is_obj;  assign iso[1] = if_b.is_obj;  assign iso[2] = if_c.is_obj;
  assign rgb[0] = if_a.obj_rgb; assign rgb[1] = if_b.obj_rgb; assign rgb[2] = if_c.obj_rgb;
  assign ht[0] = if_a.hit;      assign ht[1] = if_b.hit;      assign ht[2] = if_c.hit;

  int checks = 0;
  int errors = 0;

  // Behavioural model: spawn (100,200), vertical motion, trigger on kid_x.
  int p_accel[3] = '{0, 1, 0};
  int p_maxv[3]  = '{8, 3, 8};
  int p_mode[3]  = '{0, 0, 1};
  int p_dly[3]   = '{60, 60, 3};
  int m_state[3], m_y[3], m_vel[3], m_cnt[3];
  int m_frame;

  task automatic model_restart();
    for (int k = 0; k < 3; k++) begin
      m_state[k] = S_IDLE; m_y[k] = 200; m_vel[k] = 0; m_cnt[k] = 0;
    end
    m_frame = 0;
  endtask

  task automatic model_tick();
    for (int k = 0; k < 3; k++) begin
      if (m_state[k] == S_IDLE) begin
        if (int'(kid_x) >= 100 - 22 && int'(kid_x) < 100 + 22) begin
          m_state[k] = S_MOVING; m_vel[k] = 1;
        end
      end else if (m_state[k] == S_MOVING) begin
        m_y[k] = m_y[k] + m_vel[k];
        m_vel[k] = m_vel[k] + p_accel[k];
        if (m_vel[k] > p_maxv[k]) m_vel[k] = p_maxv[k];
        if (m_vel[k] < -p_maxv[k]) m_vel[k] = -p_maxv[k];
        if (m_y[k] + 24 <= 0 || m_y[k] >= 600) begin
          if (p_mode[k] == 1) begin m_state[k] = S_WAIT; m_cnt[k] = p_dly[k]; end
          else m_state[k] = S_DONE;
        end
      end else if (m_state[k] == S_WAIT) begin
        m_cnt[k] = m_cnt[k] - 1;
        if (m_cnt[k] <= 0) begin
          m_state[k] = S_IDLE; m_y[k] = 200; m_vel[k] = 0; m_cnt[k] = 0;
        end
      end
    end
  endtask

  function automatic bit model_visible(input int k);
    return (m_state[k] == S_IDLE || m_state[k] == S_MOVING) && m_y[k] >= 0 && m_y[k] + 3 <= 1023;
  endfunction

  // Probe address for pixel (x+5, y+3) of the current frame.
  function automatic int probe_addr();
    return m_frame * 22 * 24 + 3 * 22 + 5;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_tick(input bit tog);
    @(negedge clk);
    update_tick = 1'b1; toggle_tick = tog;
    @(negedge clk);
    update_tick = 1'b0; toggle_tick = 1'b0;
    model_tick();
    if (tog) m_frame = (m_frame + 1) % 2;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    model_restart();
  endtask

  task automatic do_toggle();
    @(negedge clk);
    toggle_tick = 1'b1;
    @(negedge clk);
    toggle_tick = 1'b0;
    m_frame = (m_frame + 1) % 2;
  endtask

  task automatic set_pix(input int c, input int r);
    col = 10'(c); row = 10'(r);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      checks++; if (st[k] !== 2'd0) begin errors++; $display("FAIL reset_state dut%0d got=%0d exp=0", k, st[k]); end
      checks++; if (ra[k] !== 11'd0) begin errors++; $display("FAIL reset_rom_addr dut%0d got=%0d exp=0", k, ra[k]); end
      checks++; if (iso[k] !== 1'b0) begin errors++; $display("FAIL reset_is_obj dut%0d got=%b exp=0", k, iso[k]); end
      checks++; if (rgb[k] !== 12'h000) begin errors++; $display("FAIL reset_obj_rgb dut%0d got=%h exp=000", k, rgb[k]); end
      checks++; if (ht[k] !== 1'b0) begin errors++; $display("FAIL reset_hit dut%0d got=%b exp=0", k, ht[k]); end
    end
    rst_n = 1'b1;
    model_restart();
  endtask

  task automatic test_idle_hold();
    kid_x = 10'd300;
    repeat (10) do_tick(1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (st[k] !== 2'(S_IDLE)) begin errors++; $display("FAIL idle_state dut%0d got=%0d exp=%0d", k, st[k], S_IDLE); end
      set_pix(105, 200 + 3);
      checks++; if (ra[k] !== 11'(probe_addr())) begin errors++; $display("FAIL idle_pos dut%0d addr got=%0d exp=%0d", k, ra[k], probe_addr()); end
    end
  endtask

  task automatic test_trigger_accel();
    int ya[5] = '{201, 202, 203, 204, 205};
    int yb[5] = '{201, 203, 206, 209, 212};
    do_restart();
    kid_x = 10'd90;
    do_tick(1'b0);
    for (int k = 0; k < 3; k++) begin
      checks++; if (st[k] !== 2'(S_MOVING)) begin errors++; $display("FAIL trigger_state dut%0d got=%0d exp=%0d", k, st[k], S_MOVING); end
      set_pix(105, 203);
      checks++; if (ra[k] !== 11'd71) begin errors++; $display("FAIL trigger_no_move dut%0d addr got=%0d exp=71", k, ra[k]); end
    end
    for (int i = 0; i < 5; i++) begin
      do_tick(1'b0);
      set_pix(105, ya[i] + 3);
      checks++; if (ra[0] !== 11'd71) begin errors++; $display("FAIL move_y dut0 step%0d addr got=%0d exp=71 (y=%0d)", i, ra[0], ya[i]); end
      set_pix(105, yb[i] + 3);
      checks++; if (ra[1] !== 11'd71) begin errors++; $display("FAIL accel_y dut1 step%0d addr got=%0d exp=71 (y=%0d)", i, ra[1], yb[i]); end
    end
  endtask

  task automatic test_oneshot();
    int n = 0;
    kid_x = 10'd300;
    while (st[0] !== 2'(S_DONE) && n < 700) begin
      do_tick(1'b0);
      n++;
      for (int k = 0; k < 3; k++) begin
        checks++; if (st[k] !== 2'(m_state[k])) begin errors++; $display("FAIL oneshot_run_state dut%0d tick%0d got=%0d exp=%0d", k, n, st[k], m_state[k]); end
      end
    end
    checks++; if (st[0] !== 2'(S_DONE)) begin errors++; $display("FAIL oneshot_done_timeout got=%0d exp=%0d", st[0], S_DONE); end
    kid_x = 10'd95; kid_y = 10'd595; rom_rgb = 12'hF00;
    set_pix(105, 605);
    for (int i = 0; i < 100; i++) begin
      do_tick(1'b0);
      checks++; if (iso[0] !== 1'b0) begin errors++; $display("FAIL done_is_obj tick%0d got=%b exp=0", i, iso[0]); end
      checks++; if (ht[0] !== 1'b0) begin errors++; $display("FAIL done_hit tick%0d got=%b exp=0", i, ht[0]); end
      checks++; if (st[2] !== 2'(m_state[2])) begin errors++; $display("FAIL done_respawn_state dut2 tick%0d got=%0d exp=%0d", i, st[2], m_state[2]); end
    end
    rom_rgb = 12'h000; kid_x = 10'd300; kid_y = 10'd0;
    do_restart();
    checks++; if (st[0] !== 2'(S_IDLE)) begin errors++; $display("FAIL restart_state got=%0d exp=0", st[0]); end
    set_pix(105, 203);
    checks++; if (ra[0] !== 11'd71) begin errors++; $display("FAIL restart_pos addr got=%0d exp=71", ra[0]); end
  endtask

  task automatic test_respawn();
    int n = 0;
    do_restart();
    kid_x = 10'd90;
    while (st[2] !== 2'(S_WAIT) && n < 700) begin
      do_tick(1'b0);
      n++;
    end
    checks++; if (st[2] !== 2'(S_WAIT)) begin errors++; $display("FAIL respawn_wait_timeout got=%0d exp=%0d", st[2], S_WAIT); end
    for (int i = 0; i < 2; i++) begin
      do_tick(1'b0);
      checks++; if (st[2] !== 2'(S_WAIT)) begin errors++; $display("FAIL respawn_waiting step%0d got=%0d exp=%0d", i, st[2], S_WAIT); end
    end
    do_tick(1'b0);
    checks++; if (st[2] !== 2'(S_IDLE)) begin errors++; $display("FAIL respawn_idle got=%0d exp=0", st[2]); end
    set_pix(105, 203);
    checks++; if (ra[2] !== 11'd71) begin errors++; $display("FAIL respawn_pos addr got=%0d exp=71", ra[2]); end
    do_tick(1'b0);
    checks++; if (st[2] !== 2'(S_MOVING)) begin errors++; $display("FAIL respawn_retrigger got=%0d exp=%0d", st[2], S_MOVING); end
  endtask

  task automatic test_pixel();
    int c, r, exp_addr;
    bit inb;
    logic [11:0] d;
    kid_x = 10'd300;
    do_restart();
    do_toggle();
    @(negedge clk);
    set_pix(105, 202);
    checks++; if (ra[0] !== 11'd577) begin errors++; $display("FAIL pix_addr got=%0d exp=577", ra[0]); end
    @(negedge clk);
    rom_rgb = 12'hF00; #1;
    checks++; if (iso[0] !== 1'b1) begin errors++; $display("FAIL pix_opaque is_obj got=%b exp=1", iso[0]); end
    checks++; if (rgb[0] !== 12'hF00) begin errors++; $display("FAIL pix_opaque rgb got=%h exp=F00", rgb[0]); end
    @(negedge clk);
    rom_rgb = 12'h000; #1;
    checks++; if (iso[0] !== 1'b0) begin errors++; $display("FAIL pix_key is_obj got=%b exp=0", iso[0]); end
    checks++; if (rgb[0] !== 12'h000) begin errors++; $display("FAIL pix_key rgb got=%h exp=000", rgb[0]); end
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      c = $urandom_range(90, 130);
      r = $urandom_range(190, 230);
      set_pix(c, r);
      inb = (c - 100 >= 0) && (c - 100 < 22) && (r - 200 >= 0) && (r - 200 < 24);
      exp_addr = inb ? (m_frame * 528 + (r - 200) * 22 + (c - 100)) : 0;
      for (int k = 0; k < 3; k++) begin
        checks++; if (ra[k] !== 11'(exp_addr)) begin errors++; $display("FAIL pix_rand_addr dut%0d col=%0d row=%0d got=%0d exp=%0d", k, c, r, ra[k], exp_addr); end
      end
      @(negedge clk);
      d = ($urandom_range(0, 3) == 0) ? 12'h000 : 12'($urandom_range(1, 4095));
      rom_rgb = d; #1;
      checks++; if (iso[0] !== (inb && d != 12'h000)) begin errors++; $display("FAIL pix_rand_is_obj col=%0d row=%0d got=%b exp=%b", c, r, iso[0], inb && d != 12'h000); end
      checks++; if (rgb[0] !== ((inb && d != 12'h000) ? d : 12'h000)) begin errors++; $display("FAIL pix_rand_rgb got=%h data=%h", rgb[0], d); end
    end
    rom_rgb = 12'h000;
    do_toggle();
    set_pix(105, 202);
    checks++; if (ra[0] !== 11'd49) begin errors++; $display("FAIL frame_wrap addr got=%0d exp=49", ra[0]); end
  endtask

  task automatic test_hit();
    int kx, ky;
    bit e;
    do_restart();
    @(negedge clk);
    kid_x = 10'd95; kid_y = 10'd190;
    @(negedge clk);
    checks++; if (ht[0] !== 1'b1) begin errors++; $display("FAIL hit_basic got=%b exp=1", ht[0]); end
    for (int i = 0; i < 30; i++) begin
      kx = $urandom_range(60, 140);
      ky = $urandom_range(160, 240);
      kid_x = 10'(kx); kid_y = 10'(ky);
      e = (kx < 100 + 22) && (100 < kx + 11) && (ky < 200 + 24) && (200 < ky + 21);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        checks++; if (ht[k] !== e) begin errors++; $display("FAIL hit_rand dut%0d kid=(%0d,%0d) got=%b exp=%b", k, kx, ky, ht[k], e); end
      end
    end
    kid_y = 10'd0;
  endtask

  task automatic test_restart_race();
    do_restart();
    kid_x = 10'd90;
    repeat (3) do_tick(1'b0);
    @(negedge clk);
    restart = 1'b1; update_tick = 1'b1;
    @(negedge clk);
    restart = 1'b0; update_tick = 1'b0;
    model_restart();
    for (int k = 0; k < 3; k++) begin
      checks++; if (st[k] !== 2'(S_IDLE)) begin errors++; $display("FAIL race_state dut%0d got=%0d exp=0", k, st[k]); end
      set_pix(105, 203);
      checks++; if (ra[k] !== 11'd71) begin errors++; $display("FAIL race_pos dut%0d addr got=%0d exp=71", k, ra[k]); end
    end
  endtask

  task automatic test_random_run();
    do_restart();
    for (int i = 0; i < 150; i++) begin
      kid_x = 10'($urandom_range(50, 150));
      if ($urandom_range(0, 49) == 0) do_restart();
      else do_tick(1'($urandom_range(0, 1)));
      for (int k = 0; k < 3; k++) begin
        checks++; if (st[k] !== 2'(m_state[k])) begin errors++; $display("FAIL rand_state dut%0d iter%0d got=%0d exp=%0d", k, i, st[k], m_state[k]); end
        if (model_visible(k)) begin
          set_pix(105, m_y[k] + 3);
          checks++; if (ra[k] !== 11'(probe_addr())) begin errors++; $display("FAIL rand_pos dut%0d iter%0d y=%0d addr got=%0d exp=%0d", k, i, m_y[k], ra[k], probe_addr()); end
        end
      end
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle_hold();
    test_trigger_accel();
    test_oneshot();
    test_respawn();
    test_pixel();
    test_hit();
    test_restart_race();
    test_random_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/trap_sprite.md
# trap_sprite

Parametrised moving-trap sprite: a rectangular object that sits at its spawn point until the kid enters a trigger window, then moves along one axis with configurable speed and acceleration. Supports one-shot or respawn behaviour, multi-frame animation, colour-key transparency and kid collision detection. Sits between the game-logic tick generator and the VGA pixel mux; it replaces per-object hard-coded traps. Sprite pixels come from an external ROM with 1-cycle read latency.

## Interface
- INIT_X, 100: spawn x (pixels, signed).
- INIT_Y, 200: spawn y (pixels, signed).
- OBJ_W, 22 / OBJ_H, 24: sprite size.
- AXIS, 0: 0 = vertical motion, 1 = horizontal motion.
- INIT_VEL, 1: signed pixels per update tick after trigger.
- ACCEL, 0: signed velocity change per update tick.
- MAX_VEL, 8: velocity magnitude saturation (positive).
- TRIG_AXIS, 0: 0 = trigger on kid_x, 1 = trigger on kid_y.
- TRIG_W, 22: trigger half-window around spawn coordinate.
- MODE, 0: 0 = one-shot, 1 = respawn.
- RESPAWN_DLY, 60: update ticks spent off-screen before respawn.
- FRAMES, 2: animation frame count (≥1).
- KID_W, 11 / KID_H, 21: kid hitbox size.
- COLOR_KEY, 12'h000: transparent colour.
- ADDR_W, 11: ROM address width; must hold FRAMES*OBJ_W*OBJ_H.
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- restart  in  1  synchronous one-cycle pulse: return to spawn/IDLE.
- update_tick  in  1  one-cycle motion strobe.
- toggle_tick  in  1  one-cycle animation strobe.
- col, row  in  10 each  current pixel.
- kid_x, kid_y  in  10 each  kid top-left.
- rom_addr  out  ADDR_W  combinational sprite ROM address.
- rom_rgb  in  12  ROM data, valid 1 cycle after rom_addr.
- is_obj  out  1  opaque sprite pixel, aligned with obj_rgb.
- obj_rgb  out  12  pixel colour.
- hit  out  1  registered kid/object overlap.
- state_o  out  2  current state (debug).

## Operation
- States: IDLE (at spawn, visible), MOVING, DONE (invisible, terminal until restart), WAIT (invisible, counting down).
- IDLE: on update_tick, if trigger coordinate t satisfies pos_t − TRIG_W ≤ t < pos_t + TRIG_W (signed, 12 bit), go to MOVING with vel = INIT_VEL. No motion on the trigger tick.
- MOVING, each update_tick: pos_axis += vel; then vel += ACCEL, saturated to ±MAX_VEL. Position uses the pre-update vel.
- Off-screen: (pos + size ≤ 0) or (pos ≥ 800 for x / 600 for y), evaluated on the updated position. MODE 0 → DONE. MODE 1 → WAIT with counter = RESPAWN_DLY.
- WAIT: counter decrements per update_tick; at 0, position ← spawn, vel ← 0, → IDLE.
- restart or reset: pos ← (INIT_X, INIT_Y), vel ← 0, counter ← 0, frame ← 0, → IDLE. restart beats a simultaneous update_tick.
- Frame index increments on toggle_tick, wrapping at FRAMES−1 → 0. It runs in all states.
- Pixel path: in_box = 0 ≤ col−x < OBJ_W and 0 ≤ row−y < OBJ_H (signed). rom_addr = frame*OBJ_W*OBJ_H + (row−y)*OBJ_W + (col−x) when in_box, else 0. in_box is registered as in_box_d, and is gated by visible (IDLE or MOVING).
- is_obj = in_box_d & (rom_rgb ≠ COLOR_KEY). obj_rgb = rom_rgb when is_obj, else 0.
- hit: registered each cycle. It is 1 when visible and the kid box [kid_x, kid_x+KID_W) × [kid_y, kid_y+KID_H) overlaps the object box.
- Positions and velocity are 12-bit signed. Velocity is clamped and positions stay in range by construction (off-screen exit).

## Timing
- Reset values: state IDLE, rom_addr 0, is_obj 0, obj_rgb 0, hit 0, state_o 0.
- Pixel latency: col/row at cycle c → is_obj/obj_rgb at c+1.
- State, position and velocity change only on the cycle after update_tick/restart. hit reflects the position one cycle later.
- Ticks are single-cycle, synchronous to clk. update_tick and toggle_tick may coincide; they are handled independently.

## Structure
- Shared package trap_pkg holds: the state enum (IDLE=0, MOVING=1, DONE=2, WAIT=3), MODE constants, SCREEN_W=800, SCREEN_H=600, the signed position width (12).
- One sub-module, trap_motion: holds the state machine, position, velocity and respawn counter. The top holds the pixel path, frame counter and hit detection.

## Test plan
- Defaults, kid_x=300: 10 update_ticks → state IDLE, y=200. Set kid_x=90 → IDLE→MOVING; y=201 after next tick, 202 after the following.
- ACCEL=1, MAX_VEL=3, vertical: successive y after trigger = 201, 203, 206, 209, 212 (saturated at 3).
- MODE 0: object reaches y ≥ 600 → DONE; is_obj and hit stay 0 for 100 ticks; restart → IDLE at (100,200).
- MODE 1, RESPAWN_DLY=3: exit screen → WAIT; after 3 ticks back in IDLE at spawn; re-triggers normally.
- Pixel: object at (100,200), frame 1, col=105, row=202 → rom_addr = 528+44+5 = 577; rom_rgb=12'hF00 next cycle → is_obj=1, obj_rgb=F00. rom_rgb=000 → is_obj=0.
- Hit/restart race: kid at (95,190) with object at (100,200) → hit=1. restart and update_tick in the same cycle → spawn position kept, state IDLE.
